// File: rtl/vga_scan_gen.sv
// VGA raster scan generator with a latency-matched sync/enable pipeline for a pixel source.
// Build option: define VGA_TEST_PATTERN_EN to replace pix_color_i with eight built-in vertical color bars.
module vga_scan_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int PIX_X_W   = 12,
  parameter int PIX_Y_W   = 12,
  parameter int COLOR_LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [PIX_X_W-1:0] pos_x_o,
  output logic [PIX_Y_W-1:0] pos_y_o,
  input  logic [2:0]         pix_color_i,
  output logic               frame_start_o,
  output logic [2:0]         vga_rgb_o,
  output logic               vga_hs_o,
  output logic               vga_vs_o,
  output logic               vga_de_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_TEST_PATTERN_EN
  // Pipeline word: {bar color, de, hs, vs}
  localparam int DW = 6;
  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
`else
  // Pipeline word: {de, hs, vs}
  localparam int DW = 3;
`endif
  localparam logic [DW-1:0] DLY_RST = DW'(3'b011);

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic          raw_de_s;
  logic          raw_hs_s;
  logic          raw_vs_s;
  logic [DW-1:0] raw_s;
  logic [DW-1:0] dly_s;
  logic [2:0]    color_s;

  // Horizontal/vertical scan counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_r <= {HW{1'b0}};
      v_cnt_r <= {VW{1'b0}};
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= {HW{1'b0}};
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= {VW{1'b0}};
      end else begin
        v_cnt_r <= v_cnt_r + VW'(1);
      end
    end else begin
      h_cnt_r <= h_cnt_r + HW'(1);
    end
  end

  assign pos_x_o       = PIX_X_W'(h_cnt_r);
  assign pos_y_o       = PIX_Y_W'(v_cnt_r);
  assign frame_start_o = !rst_i && (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});

  // Undelayed timing qualifiers for the current scan position
  always_comb begin
    raw_de_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    raw_hs_s = !((h_cnt_r >= HS_BEG) && (h_cnt_r <= HS_END));
    raw_vs_s = !((v_cnt_r >= VS_BEG) && (v_cnt_r <= VS_END));
  end

`ifdef VGA_TEST_PATTERN_EN
  assign raw_s = {3'(h_cnt_r / BAR_W), raw_de_s, raw_hs_s, raw_vs_s};
`else
  assign raw_s = {raw_de_s, raw_hs_s, raw_vs_s};
`endif

  // Delay line matching the pixel source latency; zero depth is a plain wire
  generate
    if (COLOR_LAT == 0) begin : g_nodly
      assign dly_s = raw_s;
    end else begin : g_dly
      logic [DW-1:0] pipe_r [COLOR_LAT];

      // Shift raw qualifiers one stage per clock
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < COLOR_LAT; i++) begin
            pipe_r[i] <= DLY_RST;
          end
        end else begin
          pipe_r[0] <= raw_s;
          for (int i = 1; i < COLOR_LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign dly_s = pipe_r[COLOR_LAT-1];
    end
  endgenerate

  // Select the color entering the output stage; blanking is forced black
  always_comb begin
    color_s = 3'b000;
    if (dly_s[2]) begin
`ifdef VGA_TEST_PATTERN_EN
      color_s = dly_s[5:3];
`else
      color_s = pix_color_i;
`endif
    end else begin
      color_s = 3'b000;
    end
  end

  // Registered pin stage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vga_rgb_o <= 3'b000;
      vga_hs_o  <= 1'b1;
      vga_vs_o  <= 1'b1;
      vga_de_o  <= 1'b0;
    end else begin
      vga_rgb_o <= color_s;
      vga_hs_o  <= dly_s[1];
      vga_vs_o  <= dly_s[0];
      vga_de_o  <= dly_s[2];
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Randomized scoreboard bench for vga_scan_gen using a reduced raster so several frames fit in a short run.
module tb_vga_scan_gen;

  localparam int H_ACTIVE = 64;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_ACTIVE = 12;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int L        = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk;
  logic        rst;
  logic [11:0] pos_x;
  logic [11:0] pos_y;
  logic [2:0]  pix_color;
  logic        frame_start;
  logic [2:0]  vga_rgb;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;

  vga_scan_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_X_W(12), .PIX_Y_W(12), .COLOR_LAT(L)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pos_x_o(pos_x), .pos_y_o(pos_y),
    .pix_color_i(pix_color), .frame_start_o(frame_start), .vga_rgb_o(vga_rgb),
    .vga_hs_o(vga_hs), .vga_vs_o(vga_vs), .vga_de_o(vga_de)
  );

  typedef struct {
    int px;
    int py;
    int fs;
    int rgb;
    int hs;
    int vs;
    int de;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bit   have     = 1'b0;
  bit   prev_rst = 1'b1;
  int   a_prev   = 0;
  int   prev_col = 0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int expv);
    n_checks++;
    if (act !== 32'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Output of the raster for scan index m (frames laid end to end), given the color fed in for it.
  function automatic exp_t vga_of(input int m, input int col, input bit blank_reset);
    exp_t e;
    int h;
    int v;
    e = '{default: 0};
    if (blank_reset) begin
      e.rgb = 0; e.hs = 1; e.vs = 1; e.de = 0;
    end else begin
      h = m % H_TOTAL;
      v = (m / H_TOTAL) % V_TOTAL;
      e.de = (h < H_ACTIVE && v < V_ACTIVE) ? 1 : 0;
      e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1;
      e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1;
`ifdef VGA_TEST_PATTERN_EN
      e.rgb = e.de ? ((h / (H_ACTIVE / 8)) % 8) : 0;
`else
      e.rgb = e.de ? col : 0;
`endif
    end
    return e;
  endfunction

  // mode 0: random color, 1: constant 3'b101, 2: pixel source returning x[2:0] after L clocks
  task automatic step(input bit r, input int mode);
    int   a_now;
    int   col;
    int   idx;
    exp_t e;
    @(posedge clk);
    #1;
    a_now = prev_rst ? 0 : a_prev + 1;
    case (mode)
      1: col = 5;
      2: begin
        idx = a_now - L;
        col = (idx < 0) ? int'($urandom_range(0, 7)) : (idx % H_TOTAL) % 8;
      end
      default: col = int'($urandom_range(0, 7));
    endcase
    rst       = r;
    pix_color = 3'(col);
    if (have) begin
      e    = vga_of(a_prev - L, prev_col, prev_rst || (a_prev - L < 0));
      e.px = a_now % H_TOTAL;
      e.py = (a_now / H_TOTAL) % V_TOTAL;
      e.fs = (!r && (a_now % FRAME == 0)) ? 1 : 0;
      q.push_back(e);
    end
    have     = have | r;
    prev_rst = r;
    a_prev   = a_now;
    prev_col = col;
  endtask

  // Monitor: every clock the DUT presents a full output set; compare against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pos_x", 32'(pos_x), e.px);
      check("pos_y", 32'(pos_y), e.py);
      check("frame_start", 32'(frame_start), e.fs);
      check("vga_rgb", 32'(vga_rgb), e.rgb);
      check("vga_hs", 32'(vga_hs), e.hs);
      check("vga_vs", 32'(vga_vs), e.vs);
      check("vga_de", 32'(vga_de), e.de);
    end
  end

  initial begin
    int target;
    int guard;
    rst       = 1'b1;
    pix_color = 3'b000;

    repeat (3) step(1'b1, 0);
    for (int i = 0; i < 2 * FRAME + 50; i++) step(1'b0, 0);

    // Abort a frame mid-line, then restart from (0,0)
    target = 8 * H_TOTAL + 30;
    guard  = 0;
    while (!(!prev_rst && ((a_prev + 1) % FRAME == target)) && guard < 2 * FRAME) begin
      step(1'b0, 0);
      guard++;
    end
    check("reset_target_reached", 32'(guard < 2 * FRAME), 1);
    step(1'b1, 0);

    for (int i = 0; i < FRAME + 100; i++) step(1'b0, 1);
    for (int i = 0; i < FRAME + 100; i++) step(1'b0, 2);
    for (int i = 0; i < 2 * FRAME; i++) step(($urandom_range(0, 499) == 0), 0);
    repeat (5) step(1'b0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
